// File: rtl/rom_loader_if.sv
// rom_loader_if: groups the host download stream, the SDRAM write port and the loader
// status outputs into one bundle.
//   master : the loader (drives ioctl_wait, sdram_wr/clkref/waddr/din, status outputs)
//   slave  : host + SDRAM controller side (drives ioctl_*, sdram_wr_rdy)
// Signals:
//   ioctl_download, ioctl_wr, ioctl_addr[24:0], ioctl_dout[7:0], ioctl_wait
//   sdram_wr, sdram_clkref, sdram_waddr[24:0], sdram_din[15:0], sdram_wr_rdy
//   load_done, words_written[23:0], checksum[15:0]
interface rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        sdram_wr;
  logic        sdram_clkref;
  logic [24:0] sdram_waddr;
  logic [15:0] sdram_din;
  logic        sdram_wr_rdy;
  logic        load_done;
  logic [23:0] words_written;
  logic [15:0] checksum;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdram_wr_rdy,
    output ioctl_wait, sdram_wr, sdram_clkref, sdram_waddr, sdram_din,
    output load_done, words_written, checksum
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdram_wr_rdy,
    input  ioctl_wait, sdram_wr, sdram_clkref, sdram_waddr, sdram_din,
    input  load_done, words_written, checksum
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: packs the 8-bit host download stream into 16-bit little-endian words and
// writes them to SDRAM through a request/ready port. Runs entirely in the SDRAM clock domain.
// Ports:
//   sdram_clk : clock (rising edge)
//   reset     : synchronous, active-high
//   ldr_io    : rom_loader_if.master (download stream, SDRAM write port, status)
// Parameters:
//   BASE_ADDR : byte offset added to ioctl_addr
//   PAD_BYTE  : fill for the missing half of an incomplete word
// Optional feature: define LOADER_CHECKSUM_EN to enable the 16-bit running sum of
// accepted words; otherwise checksum is tied to zero.
module rom_loader #(
  parameter logic [24:0] BASE_ADDR = 25'h0000000,
  parameter logic [7:0]  PAD_BYTE  = 8'hFF
) (
  input logic          sdram_clk,
  input logic          reset,
  rom_loader_if.master ldr_io
);

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e      state_q;
  logic        dl_q;
  logic        wait_q, wr_q, clkref_q, load_done_q;
  logic [24:0] waddr_q;
  logic [15:0] din_q;
  logic [23:0] words_q;
  // One-entry side register for a byte that arrived while a held byte had to be flushed.
  logic        side_valid_q, side_odd_q;
  logic [7:0]  side_byte_q;
  logic [24:0] side_addr_q;
  // FILL holding an already formed {odd, PAD} word that must be requested next cycle.
  logic        odd_hold_q;
  // Download ended while a write was still in flight.
  logic        done_pend_q;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q;
`endif

  logic        rise, fall, byte_acc, byte_odd, accept;
  logic [24:0] word_addr;

  assign rise      = ldr_io.ioctl_download & ~dl_q;
  assign fall      = ~ldr_io.ioctl_download & dl_q;
  assign byte_acc  = ldr_io.ioctl_download & ldr_io.ioctl_wr & ~wait_q;
  assign byte_odd  = ldr_io.ioctl_addr[0];
  assign word_addr = (ldr_io.ioctl_addr + BASE_ADDR) & ~25'd1;
  assign accept    = wr_q & ldr_io.sdram_wr_rdy;

  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dl_q         <= 1'b0;
      wait_q       <= 1'b0;
      wr_q         <= 1'b0;
      clkref_q     <= 1'b0;
      load_done_q  <= 1'b0;
      waddr_q      <= '0;
      din_q        <= '0;
      words_q      <= '0;
      side_valid_q <= 1'b0;
      side_odd_q   <= 1'b0;
      side_byte_q  <= '0;
      side_addr_q  <= '0;
      odd_hold_q   <= 1'b0;
      done_pend_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      dl_q     <= ldr_io.ioctl_download;
      clkref_q <= 1'b0;
      if (rise) begin
        // New image: abandon anything in flight and restart the counters.
        state_q      <= StIdle;
        load_done_q  <= 1'b0;
        words_q      <= '0;
        wait_q       <= 1'b0;
        wr_q         <= 1'b0;
        side_valid_q <= 1'b0;
        odd_hold_q   <= 1'b0;
        done_pend_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (fall) begin
              // load_done follows one cycle later, from StDone.
              state_q <= StDone;
            end else if (byte_acc) begin
              waddr_q <= word_addr;
              if (!byte_odd) begin
                din_q[7:0] <= ldr_io.ioctl_dout;
                state_q    <= StFill;
              end else begin
                din_q    <= {ldr_io.ioctl_dout, PAD_BYTE};
                wr_q     <= 1'b1;
                clkref_q <= 1'b1;
                wait_q   <= 1'b1;
                state_q  <= StWrite;
              end
            end
          end

          StFill: begin
            if (odd_hold_q) begin
              if (fall) done_pend_q <= 1'b1;
              odd_hold_q <= 1'b0;
              wr_q       <= 1'b1;
              clkref_q   <= 1'b1;
              wait_q     <= 1'b1;
              state_q    <= StWrite;
            end else if (fall || done_pend_q) begin
              din_q[15:8] <= PAD_BYTE;
              done_pend_q <= 1'b1;
              wr_q        <= 1'b1;
              clkref_q    <= 1'b1;
              wait_q      <= 1'b1;
              state_q     <= StWrite;
            end else if (byte_acc) begin
              wr_q     <= 1'b1;
              clkref_q <= 1'b1;
              wait_q   <= 1'b1;
              state_q  <= StWrite;
              if (byte_odd && (word_addr == waddr_q)) begin
                din_q[15:8] <= ldr_io.ioctl_dout;
              end else begin
                // Flush the held byte padded; park the new byte until the flush lands.
                din_q[15:8]  <= PAD_BYTE;
                side_valid_q <= 1'b1;
                side_odd_q   <= byte_odd;
                side_byte_q  <= ldr_io.ioctl_dout;
                side_addr_q  <= word_addr;
              end
            end
          end

          StWrite: begin
            if (fall) done_pend_q <= 1'b1;
            if (accept) begin
              words_q <= words_q + 24'd1;
`ifdef LOADER_CHECKSUM_EN
              csum_q  <= csum_q + din_q;
`endif
              wr_q    <= 1'b0;
              wait_q  <= 1'b0;
              if (side_valid_q) begin
                side_valid_q <= 1'b0;
                waddr_q      <= side_addr_q;
                state_q      <= StFill;
                if (side_odd_q) begin
                  din_q      <= {side_byte_q, PAD_BYTE};
                  odd_hold_q <= 1'b1;
                  wait_q     <= 1'b1;
                end else begin
                  din_q[7:0] <= side_byte_q;
                end
              end else if (done_pend_q || fall) begin
                done_pend_q <= 1'b0;
                load_done_q <= 1'b1;
                state_q     <= StDone;
              end else begin
                state_q <= StIdle;
              end
            end
          end

          StDone: begin
            load_done_q <= 1'b1;
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ldr_io.ioctl_wait    = wait_q;
  assign ldr_io.sdram_wr      = wr_q;
  assign ldr_io.sdram_clkref  = clkref_q;
  assign ldr_io.sdram_waddr   = waddr_q;
  assign ldr_io.sdram_din     = din_q;
  assign ldr_io.load_done     = load_done_q;
  assign ldr_io.words_written = words_q;
`ifdef LOADER_CHECKSUM_EN
  assign ldr_io.checksum      = csum_q;
`else
  assign ldr_io.checksum      = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
module tb_rom_loader;
  localparam logic [24:0] Base = 25'h0000000;
  localparam logic [7:0]  Pad  = 8'hFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rom_loader_if bus();

  rom_loader #(.BASE_ADDR(Base), .PAD_BYTE(Pad)) dut (
    .sdram_clk(clk),
    .reset    (reset),
    .ldr_io   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic [24:0] addr; logic [15:0] data;} wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];

  // Reference: pair an even byte with the odd byte of the same word, pad anything lone.
  logic        m_held;
  logic [24:0] m_haddr;
  logic [7:0]  m_hbyte;

  task automatic model_clear();
    exp_q.delete();
    got_q.delete();
    m_held = 1'b0;
  endtask

  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    logic [24:0] w;
    w = (a + Base) & ~25'd1;
    if (!a[0]) begin
      if (m_held) exp_q.push_back({m_haddr, Pad, m_hbyte});
      m_held  = 1'b1;
      m_haddr = w;
      m_hbyte = d;
    end else if (m_held && m_haddr == w) begin
      exp_q.push_back({w, d, m_hbyte});
      m_held = 1'b0;
    end else begin
      if (m_held) exp_q.push_back({m_haddr, Pad, m_hbyte});
      m_held = 1'b0;
      exp_q.push_back({w, d, Pad});
    end
  endtask

  task automatic model_end();
    if (m_held) exp_q.push_back({m_haddr, Pad, m_hbyte});
    m_held = 1'b0;
  endtask

  // Monitor: capture accepted writes, check the clkref strobe and address alignment.
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_wr = 1'b0;
    end else begin
      check("clkref_strobe", bus.sdram_clkref, bus.sdram_wr & ~prev_wr);
      if (bus.sdram_wr) check("waddr_bit0", bus.sdram_waddr[0], 1'b0);
      if (bus.sdram_wr && bus.sdram_wr_rdy) got_q.push_back({bus.sdram_waddr, bus.sdram_din});
      prev_wr = bus.sdram_wr;
    end
  end

  // Random ready driver, active only when rdy_rand is set; runs at +2ns to avoid the main flow.
  logic rdy_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_rand) bus.sdram_wr_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (bus.ioctl_wait && n < 500) begin
      step();
      n++;
    end
    if (bus.ioctl_wait) begin
      check("wait_timeout", bus.ioctl_wait, 1'b0);
      return;
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    model_byte(a, d);
    step();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    model_clear();
    bus.ioctl_download = 1'b1;
    step();
    step();
  endtask

  task automatic finish_dl(input string tag);
    int n;
    logic [15:0] sum;
    bus.ioctl_download = 1'b0;
    n = 0;
    while (!bus.load_done && n < 2000) begin
      step();
      n++;
    end
    if (!bus.load_done) check({tag, "_done_timeout"}, bus.load_done, 1'b1);
    step();
    model_end();
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    sum = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      sum = sum + exp_q[i].data;
      if (i < got_q.size()) begin
        check($sformatf("%s_w%0d_addr", tag, i), got_q[i].addr, exp_q[i].addr);
        check($sformatf("%s_w%0d_data", tag, i), got_q[i].data, exp_q[i].data);
      end
    end
    check({tag, "_words"}, bus.words_written, exp_q.size());
    check({tag, "_load_done"}, bus.load_done, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, bus.checksum, sum);
`else
    check({tag, "_checksum"}, bus.checksum, 16'h0000);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wait"},  bus.ioctl_wait, 1'b0);
    check({tag, "_wr"},    bus.sdram_wr, 1'b0);
    check({tag, "_clkref"}, bus.sdram_clkref, 1'b0);
    check({tag, "_waddr"}, bus.sdram_waddr, 25'h0);
    check({tag, "_din"},   bus.sdram_din, 16'h0);
    check({tag, "_done"},  bus.load_done, 1'b0);
    check({tag, "_words"}, bus.words_written, 24'h0);
    check({tag, "_csum"},  bus.checksum, 16'h0);
  endtask

  initial begin
    logic [24:0] a0, d0;
    logic [24:0] cur;
    int nb;

    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.sdram_wr_rdy   = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Contiguous 11,22,33,44 with ready tied high; also load_done latency from IDLE.
    bus.sdram_wr_rdy = 1'b1;
    start_dl();
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33);
    send_byte(25'd3, 8'h44);
    repeat (3) step();
    bus.ioctl_download = 1'b0;
    step();
    check("t1_done_lat1", bus.load_done, 1'b0);
    step();
    check("t1_done_lat2", bus.load_done, 1'b1);
    finish_dl("t1");
    check("t1_w0_const", {got_q.size() > 0 ? got_q[0].data : 16'hxxxx}, 16'h2211);
    check("t1_w1_const", {got_q.size() > 1 ? got_q[1].data : 16'hxxxx}, 16'h4433);
    check("t1_w1_addr_const", {got_q.size() > 1 ? got_q[1].addr : 25'hx}, 25'd2);

    // Three bytes, final word padded.
    start_dl();
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    send_byte(25'd2, 8'hCC);
    finish_dl("t2");
    check("t2_last_const", {got_q.size() > 1 ? got_q[1].data : 16'hxxxx}, 16'hFFCC);

    // Stall: ready low for 10 cycles, a strobe during the stall must be ignored.
    bus.sdram_wr_rdy = 1'b0;
    start_dl();
    send_byte(25'd1, 8'h5A);
    check("stall_wr", bus.sdram_wr, 1'b1);
    check("stall_clkref", bus.sdram_clkref, 1'b1);
    check("stall_wait", bus.ioctl_wait, 1'b1);
    check("stall_addr", bus.sdram_waddr, 25'd0);
    check("stall_din", bus.sdram_din, 16'h5AFF);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'd3;
        bus.ioctl_dout = 8'h77;
      end
      step();
      bus.ioctl_wr = 1'b0;
      check($sformatf("stall%0d_wr", i), bus.sdram_wr, 1'b1);
      check($sformatf("stall%0d_wait", i), bus.ioctl_wait, 1'b1);
      check($sformatf("stall%0d_addr", i), bus.sdram_waddr, 25'd0);
      check($sformatf("stall%0d_din", i), bus.sdram_din, 16'h5AFF);
    end
    bus.sdram_wr_rdy = 1'b1;
    step();
    check("stall_rel_wr", bus.sdram_wr, 1'b0);
    check("stall_rel_wait", bus.ioctl_wait, 1'b0);
    check("stall_rel_words", bus.words_written, 24'd1);
    finish_dl("stall");

    // Even byte at 8 then even byte at 20: flush 8 padded, FILL holds 20.
    start_dl();
    send_byte(25'd8, 8'h3C);
    send_byte(25'd20, 8'hC3);
    step();
    check("jump_fill_wr", bus.sdram_wr, 1'b0);
    check("jump_fill_addr", bus.sdram_waddr, 25'd20);
    finish_dl("jump");
    check("jump_w0_const", {got_q.size() > 0 ? got_q[0].data : 16'hxxxx}, 16'hFF3C);

    // Second download start clears the status in the cycle after the rising edge.
    bus.ioctl_download = 1'b1;
    step();
    check("restart_done", bus.load_done, 1'b0);
    check("restart_words", bus.words_written, 24'd0);
    check("restart_csum", bus.checksum, 16'h0);
    model_clear();
    finish_dl("empty");

    // Reset while a request is outstanding.
    bus.sdram_wr_rdy = 1'b0;
    start_dl();
    send_byte(25'd5, 8'h99);
    check("rst_pre_wr", bus.sdram_wr, 1'b1);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.sdram_wr_rdy = 1'b1;
    step();
    check_all_zero("rst_mid");
    reset = 1'b0;
    step();

    // Randomized downloads with random ready and gaps.
    rdy_rand = 1'b1;
    for (int t = 0; t < 6; t++) begin
      start_dl();
      nb  = $urandom_range(8, 40);
      cur = 25'($urandom_range(0, 2047));
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 4) == 0) cur = 25'($urandom_range(0, 4095));
        send_byte(cur, 8'($urandom));
        cur = cur + 25'd1;
        repeat ($urandom_range(0, 2)) step();
      end
      finish_dl($sformatf("rnd%0d", t));
    end
    rdy_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
